// File: rtl/dkong_input_pkg.sv
// Shared constants for the Donkey Kong player-input front end: PS/2 scancodes,
// joystick bit positions, direction indices and the held-key decoder.
package dkong_input_pkg;

    localparam int COIN_CNT_W = 22;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_FIRE  = 4;
    localparam int JOY_START1 = 5;
    localparam int JOY_START2 = 6;
    localparam int JOY_COIN  = 7;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_D = 2'd2,
        DIR_U = 2'd3
    } dir_e;

    // One held-key bit per physical key; functions OR several keys together.
    localparam int KEY_COUNT = 18;
    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_SPACE = 4;
    localparam int K_CTRL  = 5;
    localparam int K_P2U   = 6;
    localparam int K_P2D   = 7;
    localparam int K_P2L   = 8;
    localparam int K_P2R   = 9;
    localparam int K_P2J   = 10;
    localparam int K_F1    = 11;
    localparam int K_1     = 12;
    localparam int K_F2    = 13;
    localparam int K_2     = 14;
    localparam int K_F3    = 15;
    localparam int K_5     = 16;
    localparam int K_6     = 17;

    localparam logic [KEY_COUNT-1:0] ARROW_MASK = 18'h0000F;

    // Arrows match with or without the extended prefix; everything else needs ext=0.
    function automatic logic [KEY_COUNT-1:0] key_onehot(input logic ext, input logic [7:0] code);
        logic [KEY_COUNT-1:0] sel;
        sel = '0;
        case (code)
            SC_UP:    sel[K_UP]    = 1'b1;
            SC_DOWN:  sel[K_DOWN]  = 1'b1;
            SC_LEFT:  sel[K_LEFT]  = 1'b1;
            SC_RIGHT: sel[K_RIGHT] = 1'b1;
            SC_SPACE: sel[K_SPACE] = 1'b1;
            SC_CTRL:  sel[K_CTRL]  = 1'b1;
            SC_R:     sel[K_P2U]   = 1'b1;
            SC_F:     sel[K_P2D]   = 1'b1;
            SC_D:     sel[K_P2L]   = 1'b1;
            SC_G:     sel[K_P2R]   = 1'b1;
            SC_A:     sel[K_P2J]   = 1'b1;
            SC_F1:    sel[K_F1]    = 1'b1;
            SC_1:     sel[K_1]     = 1'b1;
            SC_F2:    sel[K_F2]    = 1'b1;
            SC_2:     sel[K_2]     = 1'b1;
            SC_F3:    sel[K_F3]    = 1'b1;
            SC_5:     sel[K_5]     = 1'b1;
            SC_6:     sel[K_6]     = 1'b1;
            default:  sel          = '0;
        endcase
        if (ext) begin
            sel = sel & ARROW_MASK;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dkong_joy4way.sv
// Per-player 4-way direction restriction: two sync stages, a last-pressed-wins
// one-hot mask, and a registered active-low direction output {U,D,L,R}.
module dkong_joy4way
    import dkong_input_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw_dir,
    output logic [3:0] dir_n
);

    logic [3:0] in1_q, in1_d;
    logic [3:0] in2_q, in2_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] dir_n_q, dir_n_d;
    logic [3:0] rise;

    always_comb begin
        in1_d  = raw_dir;
        in2_d  = in1_q;
        rise   = in1_q & ~in2_q;
        mask_d = mask_q;
        // Simultaneous rises resolve toward the higher index (U > D > L > R).
        if (rise[DIR_U]) begin
            mask_d = 4'b1000;
        end else if (rise[DIR_D]) begin
            mask_d = 4'b0100;
        end else if (rise[DIR_L]) begin
            mask_d = 4'b0010;
        end else if (rise[DIR_R]) begin
            mask_d = 4'b0001;
        end
        dir_n_d = ~(in1_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in1_q   <= '0;
            in2_q   <= '0;
            mask_q  <= '0;
            dir_n_q <= '1;
        end else begin
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            mask_q  <= mask_d;
            dir_n_q <= dir_n_d;
        end
    end

    assign dir_n = dir_n_q;

endmodule

// File: rtl/dkong_input_map.sv
// Donkey Kong player-input front end: PS/2 held-key decode merged with two
// joysticks, 4-way restriction, start/jump sync and a fixed-width coin pulse.
// Optional macro INPUT_ROTATE_EN enables the I_ROTATE direction remap.
module dkong_input_map
    import dkong_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYCLES = 2457600
) (
    input  logic        I_CLK_24576M,
    input  logic        I_RESETn,
    input  logic [10:0] I_PS2_KEY,
    input  logic [15:0] I_JOY0,
    input  logic [15:0] I_JOY1,
    input  logic        I_ROTATE,
    output logic        O_U1,
    output logic        O_D1,
    output logic        O_L1,
    output logic        O_R1,
    output logic        O_J1,
    output logic        O_U2,
    output logic        O_D2,
    output logic        O_L2,
    output logic        O_R2,
    output logic        O_J2,
    output logic        O_S1,
    output logic        O_S2,
    output logic        O_C1
);

    localparam logic [COIN_CNT_W-1:0] COIN_LOAD = COIN_CNT_W'(COIN_PULSE_CYCLES);

    logic                  old_toggle_q, old_toggle_d;
    logic [KEY_COUNT-1:0]  held_q, held_d;
    logic [KEY_COUNT-1:0]  key_sel;
    logic                  ps2_event;

    logic [3:0] p1_raw, p2_raw, p1_dir, p2_dir;
    logic [3:0] p1_dir_n, p2_dir_n;
    logic       j1_raw, j2_raw, s1_raw, s2_raw, coin_raw;

    logic [1:0] jump_s_q, jump_s_d, jump_n_q, jump_n_d;
    logic [1:0] start_s_q, start_s_d, start_n_q, start_n_d;

    logic                  req_s_q, req_s_d;
    logic                  req_d_q, req_d_d;
    logic                  seeded_q, seeded_d;
    logic [COIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                  coin_n_q, coin_n_d;

    logic unused_inputs;

    always_comb begin
        old_toggle_d = I_PS2_KEY[10];
        ps2_event    = (I_PS2_KEY[10] != old_toggle_q);
        key_sel      = key_onehot(I_PS2_KEY[8], I_PS2_KEY[7:0]);
        held_d       = held_q;
        if (ps2_event) begin
            held_d = (held_q & ~key_sel) | (key_sel & {KEY_COUNT{I_PS2_KEY[9]}});
        end
    end

    assign p1_raw = {held_q[K_UP]    | I_JOY0[JOY_U],
                     held_q[K_DOWN]  | I_JOY0[JOY_D],
                     held_q[K_LEFT]  | I_JOY0[JOY_L],
                     held_q[K_RIGHT] | I_JOY0[JOY_R]};
    assign p2_raw = {held_q[K_P2U] | I_JOY1[JOY_U],
                     held_q[K_P2D] | I_JOY1[JOY_D],
                     held_q[K_P2L] | I_JOY1[JOY_L],
                     held_q[K_P2R] | I_JOY1[JOY_R]};

    assign j1_raw   = held_q[K_SPACE] | held_q[K_CTRL] | I_JOY0[JOY_FIRE];
    assign j2_raw   = held_q[K_P2J] | I_JOY1[JOY_FIRE];
    assign s1_raw   = held_q[K_F1] | held_q[K_1] | I_JOY0[JOY_START1] | I_JOY1[JOY_START1];
    assign s2_raw   = held_q[K_F2] | held_q[K_2] | I_JOY0[JOY_START2] | I_JOY1[JOY_START2];
    assign coin_raw = held_q[K_F3] | held_q[K_5] | held_q[K_6]
                    | I_JOY0[JOY_COIN] | I_JOY1[JOY_COIN];

`ifdef INPUT_ROTATE_EN
    // Horizontal cabinet: U<-L, D<-R, L<-D, R<-U on the {U,D,L,R} vector.
    assign p1_dir = I_ROTATE ? {p1_raw[DIR_L], p1_raw[DIR_R], p1_raw[DIR_D], p1_raw[DIR_U]} : p1_raw;
    assign p2_dir = I_ROTATE ? {p2_raw[DIR_L], p2_raw[DIR_R], p2_raw[DIR_D], p2_raw[DIR_U]} : p2_raw;
    assign unused_inputs = ^{I_JOY0[15:8], I_JOY1[15:8]};
`else
    assign p1_dir = p1_raw;
    assign p2_dir = p2_raw;
    assign unused_inputs = ^{I_JOY0[15:8], I_JOY1[15:8], I_ROTATE};
`endif

    dkong_joy4way u_joy_p1 (
        .clk     (I_CLK_24576M),
        .rst_n   (I_RESETn),
        .raw_dir (p1_dir),
        .dir_n   (p1_dir_n)
    );

    dkong_joy4way u_joy_p2 (
        .clk     (I_CLK_24576M),
        .rst_n   (I_RESETn),
        .raw_dir (p2_dir),
        .dir_n   (p2_dir_n)
    );

    always_comb begin
        jump_s_d  = {j2_raw, j1_raw};
        jump_n_d  = ~jump_s_q;
        start_s_d = {s2_raw, s1_raw};
        start_n_d = ~start_s_q;

        // req_d is loaded straight from the raw request on the first clock out
        // of reset, so a request held across reset is not seen as an edge.
        req_s_d  = coin_raw;
        req_d_d  = seeded_q ? req_s_q : coin_raw;
        seeded_d = 1'b1;

        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - COIN_CNT_W'(1);
        end else if (req_s_q && !req_d_q) begin
            cnt_d = COIN_LOAD;
        end
        coin_n_d = (cnt_d == '0);
    end

    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            old_toggle_q <= 1'b0;
            held_q       <= '0;
            jump_s_q     <= '0;
            jump_n_q     <= '1;
            start_s_q    <= '0;
            start_n_q    <= '1;
            req_s_q      <= 1'b0;
            req_d_q      <= 1'b0;
            seeded_q     <= 1'b0;
            cnt_q        <= '0;
            coin_n_q     <= 1'b1;
        end else begin
            old_toggle_q <= old_toggle_d;
            held_q       <= held_d;
            jump_s_q     <= jump_s_d;
            jump_n_q     <= jump_n_d;
            start_s_q    <= start_s_d;
            start_n_q    <= start_n_d;
            req_s_q      <= req_s_d;
            req_d_q      <= req_d_d;
            seeded_q     <= seeded_d;
            cnt_q        <= cnt_d;
            coin_n_q     <= coin_n_d;
        end
    end

    assign O_U1 = p1_dir_n[DIR_U];
    assign O_D1 = p1_dir_n[DIR_D];
    assign O_L1 = p1_dir_n[DIR_L];
    assign O_R1 = p1_dir_n[DIR_R];
    assign O_J1 = jump_n_q[0];
    assign O_U2 = p2_dir_n[DIR_U];
    assign O_D2 = p2_dir_n[DIR_D];
    assign O_L2 = p2_dir_n[DIR_L];
    assign O_R2 = p2_dir_n[DIR_R];
    assign O_J2 = jump_n_q[1];
    assign O_S1 = start_n_q[0];
    assign O_S2 = start_n_q[1];
    assign O_C1 = coin_n_q;

endmodule
